// File: rtl/ram_pkg.sv
// ram_pkg -- shared definitions for the banked byte-lane data RAM.
//
// Contents:
//   ram_state_e : sweep/run state encoding for the controller FSM.
//   nb_of(dw)   : number of 8-bit byte lanes in a dw-bit word.
//   lsb_of(dw)  : number of byte-offset address bits below the word index.
package ram_pkg;

  // CLEAR: zero-fill sweep in progress, accesses ignored.
  // RUN  : normal read/write service.
  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } ram_state_e;

  // Byte lanes per data word.
  function automatic int nb_of(input int dw);
    return dw / 8;
  endfunction

  // Address bits that select a byte inside a word. These are dropped when
  // forming the word index, so unaligned addresses simply round down.
  function automatic int lsb_of(input int dw);
    return (dw <= 8) ? 0 : $clog2(dw / 8);
  endfunction

endpackage : ram_pkg

// File: rtl/ram_lane.sv
// ram_lane -- one 8-bit byte lane of the banked RAM.
//
// Simple dual-port array, 2^AW bytes deep: one write port and one read port
// with a registered (synchronous) read. The read register can be loaded with
// the byte being written this cycle instead of the stored one; the decision
// is made by the parent, which sees all lanes and the full addresses.
//
// Ports:
//   clk     in   system clock, rising edge
//   rst     in   asynchronous active-low reset (read register only)
//   we      in   write enable for this lane
//   w_idx   in   AW  write word index
//   w_byte  in   8   write data
//   re      in   read enable; loads r_byte on the next edge
//   r_idx   in   AW  read word index
//   byp     in   load w_byte instead of mem[r_idx] (write-first forwarding)
//   r_byte  out  8   registered read data; holds when re is low
module ram_lane #(
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] w_idx,
  input  logic [7:0]    w_byte,
  input  logic          re,
  input  logic [AW-1:0] r_idx,
  input  logic          byp,
  output logic [7:0]    r_byte
);

  localparam int DEPTH = 1 << AW;

  // Storage is deliberately not reset: zeroing is done by the parent's sweep
  // so the array can map onto plain block RAM.
  logic [7:0] mem [0:DEPTH-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[w_idx] <= w_byte;
    end
  end

  // The read register does reset, so the visible output is clean right after
  // reset regardless of array contents.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_byte <= '0;
    end else if (re) begin
      r_byte <= byp ? w_byte : mem[r_idx];
    end
  end

endmodule : ram_lane

// File: rtl/ram_banked.sv
// ram_banked -- parametrised byte-lane data RAM with zero-fill sweep,
// registered reads and same-word write-first forwarding.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-low reset
//   ram_en     in   chip select; qualifies ren and wen
//   wen        in   NB  per-lane write enable (bit k -> w_data_i[8k+7:8k])
//   w_addr_i   in   32  byte write address
//   w_data_i   in   DW  write data
//   ren        in   read request
//   r_addr_i   in   32  byte read address
//   clr_i      in   single-cycle request to zero-fill the array
//   r_data_o   out  DW  registered read data
//   r_valid_o  out  one-cycle strobe, r_data_o is new this cycle
//   busy_o     out  sweep in progress, accesses ignored
//   dbg_state  out  current controller state
//
// Handshake: there is no back-pressure. A qualified read (ren & ram_en &
// ~busy_o) presented before edge N produces r_valid_o high for exactly the
// cycle after edge N, with r_data_o valid alongside it; the consumer must
// take it then. With r_valid_o low, r_data_o holds its previous value.
//
// Addressing: word index = addr[AW+LSB-1:LSB]. Byte-offset bits and bits
// above the index are ignored, so unaligned addresses round down and the
// array aliases through the 32-bit address space. AW+LSB must not exceed 32.
module ram_banked
  import ram_pkg::*;
#(
  parameter int DW             = 32,
  parameter int AW             = 12,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ram_en,
  input  logic [DW/8-1:0]   wen,
  input  logic [31:0]       w_addr_i,
  input  logic [DW-1:0]     w_data_i,
  input  logic              ren,
  input  logic [31:0]       r_addr_i,
  input  logic              clr_i,
  output logic [DW-1:0]     r_data_o,
  output logic              r_valid_o,
  output logic              busy_o,
  output ram_state_e        dbg_state
);

  localparam int NB  = nb_of(DW);
  localparam int LSB = lsb_of(DW);

  // State entered on every reset release.
  localparam ram_state_e RST_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;

  // ---------------------------------------------------------------------------
  // Controller FSM and sweep counter
  // ---------------------------------------------------------------------------
  ram_state_e    state_q, state_d;
  logic [AW-1:0] sweep_q, sweep_d;
  logic          in_clear;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RST_STATE;
      sweep_q <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sweep_d  = sweep_q;
    in_clear = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        in_clear = 1'b1;
        // The counter is AW bits wide, so the increment after the last word
        // wraps to 0 by itself, leaving it ready for the next sweep.
        sweep_d  = sweep_q + AW'(1);
        if (sweep_q == '1) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        sweep_d = '0;
        // Accesses in this same cycle are still qualified (busy_o is low),
        // so they complete before the sweep starts.
        if (clr_i) begin
          state_d = ST_CLEAR;
        end
      end
      default: begin
        state_d = RST_STATE;
        sweep_d = '0;
      end
    endcase
  end

  assign busy_o    = in_clear;
  assign dbg_state = state_q;

  // ---------------------------------------------------------------------------
  // Access qualification and address decode
  // ---------------------------------------------------------------------------
  logic          acc_ok;
  logic          rd;
  logic [NB-1:0] wr;
  logic [AW-1:0] w_idx, r_idx;
  logic          same_word;

  assign acc_ok    = ram_en & ~in_clear;
  assign rd        = ren & acc_ok;
  assign wr        = wen & {NB{acc_ok}};
  assign w_idx     = w_addr_i[AW+LSB-1:LSB];
  assign r_idx     = r_addr_i[AW+LSB-1:LSB];
  assign same_word = (w_idx == r_idx);

  // Offset bits and high bits do not take part in decode; fold them into a
  // sink so the intent of ignoring them is explicit.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{w_addr_i, r_addr_i};

  // During the sweep the write port is taken over: counter address, zero
  // data, every lane enabled. User writes are already blocked by acc_ok.
  logic [AW-1:0] lane_w_idx;
  assign lane_w_idx = in_clear ? sweep_q : w_idx;

  // ---------------------------------------------------------------------------
  // Byte lanes
  // ---------------------------------------------------------------------------
  for (genvar k = 0; k < NB; k++) begin : g_lane
    logic       lane_we;
    logic [7:0] lane_w_byte;
    logic       lane_byp;

    assign lane_we     = in_clear | wr[k];
    assign lane_w_byte = in_clear ? 8'h00 : w_data_i[8*k +: 8];
    // Forward only the lanes actually written to the word being read; other
    // lanes of that word return their stored (old) byte.
    assign lane_byp    = wr[k] & same_word;

    ram_lane #(
      .AW (AW)
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .we     (lane_we),
      .w_idx  (lane_w_idx),
      .w_byte (lane_w_byte),
      .re     (rd),
      .r_idx  (r_idx),
      .byp    (lane_byp),
      .r_byte (r_data_o[8*k +: 8])
    );
  end

  // ---------------------------------------------------------------------------
  // Read valid strobe
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid_o <= 1'b0;
    end else begin
      r_valid_o <= rd;
    end
  end

endmodule : ram_banked

// File: tb/tb_ram_banked.sv
// tb_ram_banked -- self-checking bench for ram_banked (DW=32, AW=4).
module tb_ram_banked;
  import ram_pkg::*;

  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int NB    = DW / 8;
  localparam int DEPTH = 1 << AW;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              ram_en;
  logic [NB-1:0]     wen;
  logic [31:0]       w_addr_i;
  logic [DW-1:0]     w_data_i;
  logic              ren;
  logic [31:0]       r_addr_i;
  logic              clr_i;
  logic [DW-1:0]     r_data_o;
  logic              r_valid_o;
  logic              busy_o;
  ram_state_e        dbg_state;

  ram_banked #(
    .DW             (DW),
    .AW             (AW),
    .CLEAR_ON_RESET (1'b1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ram_en    (ram_en),
    .wen       (wen),
    .w_addr_i  (w_addr_i),
    .w_data_i  (w_data_i),
    .ren       (ren),
    .r_addr_i  (r_addr_i),
    .clr_i     (clr_i),
    .r_data_o  (r_data_o),
    .r_valid_o (r_valid_o),
    .busy_o    (busy_o),
    .dbg_state (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state and checker
  // ---------------------------------------------------------------------------
  int unsigned   checks   = 0;
  int unsigned   failures = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] mem_m [0:DEPTH-1];
  logic [DW-1:0] last_exp = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Read-data monitor: every negedge out of reset, a valid strobe must match
  // the oldest expected read; otherwise the output must hold.
  always @(negedge clk) begin
    if (rst) begin
      if (r_valid_o) begin
        if (exp_q.size() == 0) begin
          check_eq("unexp_valid", {31'd0, r_valid_o}, 32'd0);
        end else begin
          logic [DW-1:0] e;
          e = exp_q.pop_front();
          check_eq("rdata", r_data_o, e);
          last_exp = e;
        end
      end else begin
        check_eq("rdata_hold", r_data_o, last_exp);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic idle_inputs();
    ram_en   = 1'b0;
    wen      = '0;
    w_addr_i = '0;
    w_data_i = '0;
    ren      = 1'b0;
    r_addr_i = '0;
    clr_i    = 1'b0;
  endtask

  task automatic model_zero();
    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
  endtask

  // One RUN-state cycle, called at a negedge and returning at the next one.
  task automatic drive_cycle(input bit en, input logic [NB-1:0] we,
                             input logic [31:0] wa, input logic [DW-1:0] wd,
                             input bit re, input logic [31:0] ra, input bit clr);
    logic [AW-1:0] widx, ridx;
    logic [DW-1:0] e;
    bit            rd;
    ram_en = en; wen = we; w_addr_i = wa; w_data_i = wd;
    ren = re; r_addr_i = ra; clr_i = clr;
    widx = wa[AW+1:2];
    ridx = ra[AW+1:2];
    rd   = re && en;
    if (rd) begin
      e = mem_m[ridx];
      for (int k = 0; k < NB; k++)
        if (en && we[k] && (widx == ridx)) e[8*k +: 8] = wd[8*k +: 8];
      exp_q.push_back(e);
    end
    if (en)
      for (int k = 0; k < NB; k++)
        if (we[k]) mem_m[widx][8*k +: 8] = wd[8*k +: 8];
    if (clr) model_zero();
    @(posedge clk);
    #1;
    check_eq("rvalid", {31'd0, r_valid_o}, {31'd0, rd});
    @(negedge clk);
    idle_inputs();
  endtask

  // Count cycles with busy_o high, starting now. Optionally hammers every
  // input during the sweep; all of it must be ignored.
  task automatic measure_busy(input bit poke, output int n);
    n = 0;
    while (busy_o && n < 100) begin
      n++;
      if (poke) begin
        ram_en   = 1'b1;
        ren      = 1'b1;
        wen      = '1;
        clr_i    = 1'b1;
        w_addr_i = $urandom_range(0, 63);
        w_data_i = $urandom;
        r_addr_i = $urandom_range(0, 63);
      end
      @(posedge clk);
      #1;
    end
    idle_inputs();
    @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  int n;

  initial begin
    idle_inputs();
    model_zero();
    #1 rst = 1'b0;
    #1;
    check_eq("rst_rdata", r_data_o, 32'h0);
    check_eq("rst_rvalid", {31'd0, r_valid_o}, 32'd0);
    check_eq("rst_busy", {31'd0, busy_o}, 32'd1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    measure_busy(1'b0, n);
    check_eq("busy_len_reset", n, DEPTH);

    // Word 5 after the power-on sweep.
    drive_cycle(1'b1, '0, 32'h0, '0, 1'b1, 32'h14, 1'b0);
    check_eq("rd_w5_zero", r_data_o, 32'h0);

    // Partial-lane write over a full word; offset bits ignored.
    drive_cycle(1'b1, 4'b1111, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0);
    drive_cycle(1'b1, 4'b0001, 32'h10, 32'h000000AA, 1'b0, 32'h0, 1'b0);
    drive_cycle(1'b1, '0, 32'h0, '0, 1'b1, 32'h10, 1'b0);
    check_eq("rd_0x10", r_data_o, 32'hDEADBEAA);
    drive_cycle(1'b1, '0, 32'h0, '0, 1'b1, 32'h13, 1'b0);
    check_eq("rd_0x13", r_data_o, 32'hDEADBEAA);
    // High address bits alias onto the same word.
    drive_cycle(1'b1, '0, 32'h0, '0, 1'b1, 32'h8000_0050, 1'b0);
    check_eq("rd_alias", r_data_o, 32'hDEADBEAA);

    // Same-cycle read and write of one word: write-first per lane.
    drive_cycle(1'b1, 4'b1111, 32'h20, 32'h11223344, 1'b0, 32'h0, 1'b0);
    drive_cycle(1'b1, 4'b0101, 32'h20, 32'hAABBCCDD, 1'b1, 32'h20, 1'b0);
    check_eq("bypass", r_data_o, 32'h11BB33DD);
    drive_cycle(1'b1, '0, 32'h0, '0, 1'b1, 32'h20, 1'b0);
    check_eq("after_bypass", r_data_o, 32'h11BB33DD);

    // Random mixed traffic, back-to-back, half the time on colliding words.
    for (int i = 0; i < 40; i++) begin
      logic [31:0] wa, ra;
      wa = $urandom;
      ra = $urandom;
      if ($urandom_range(0, 1) == 1) ra[AW+1:2] = wa[AW+1:2];
      drive_cycle(1'b1, NB'($urandom_range(0, 15)), wa, $urandom,
                  bit'($urandom_range(0, 3) != 0), ra, 1'b0);
    end

    // Fill everything, then clear; the read issued with clr_i still happens.
    for (int i = 0; i < DEPTH; i++)
      drive_cycle(1'b1, 4'hF, 32'(i * 4), 32'hFFFFFFFF, 1'b0, 32'h0, 1'b0);
    drive_cycle(1'b1, '0, 32'h0, '0, 1'b1, 32'h24, 1'b1);
    check_eq("rd_with_clr", r_data_o, 32'hFFFFFFFF);
    measure_busy(1'b1, n);
    check_eq("busy_len_clr", n, DEPTH);
    for (int i = 0; i < DEPTH; i++)
      drive_cycle(1'b1, '0, 32'h0, '0, 1'b1, 32'(i * 4), 1'b0);
    check_eq("rd_last_zero", r_data_o, 32'h0);

    // Chip select low blocks both read and write.
    drive_cycle(1'b1, 4'hF, 32'h8, 32'hCAFEF00D, 1'b0, 32'h0, 1'b0);
    drive_cycle(1'b0, 4'hF, 32'h8, 32'h12345678, 1'b1, 32'h8, 1'b0);
    drive_cycle(1'b1, '0, 32'h0, '0, 1'b1, 32'h8, 1'b0);
    check_eq("rd_after_cs_low", r_data_o, 32'hCAFEF00D);

    // Reset in the middle of a sweep, with non-zero data on the output.
    drive_cycle(1'b1, '0, 32'h0, '0, 1'b1, 32'h8, 1'b1);
    repeat (7) @(posedge clk);
    #2;
    rst      = 1'b0;
    last_exp = '0;
    exp_q.delete();
    model_zero();
    #1;
    check_eq("midrst_rdata", r_data_o, 32'h0);
    check_eq("midrst_rvalid", {31'd0, r_valid_o}, 32'd0);
    check_eq("midrst_busy", {31'd0, busy_o}, 32'd1);
    #9;
    rst = 1'b1;
    #1;
    measure_busy(1'b0, n);
    check_eq("busy_len_midrst", n, DEPTH);
    drive_cycle(1'b1, '0, 32'h0, '0, 1'b1, 32'h1C, 1'b0);
    drive_cycle(1'b1, '0, 32'h0, '0, 1'b1, 32'h8, 1'b0);
    check_eq("rd_after_midrst", r_data_o, 32'h0);

    repeat (2) @(negedge clk);
    check_eq("queue_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule : tb_ram_banked
